// File: rtl/key_store_if.sv
// Producer/consumer bundle for the key FIFO.
// Signal names follow the block's external pin list.
interface key_store_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          writeReq;
    logic [31:0]   key;
    logic          writeSucceeded;
    logic [31:0]   keyOut;
    logic          keyValid;
    logic          keyTaken;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output writeReq,
        output key,
        output keyTaken,
        input  writeSucceeded,
        input  keyOut,
        input  keyValid,
        input  count,
        input  full,
        input  empty
    );

    modport slave (
        input  writeReq,
        input  key,
        input  keyTaken,
        output writeSucceeded,
        output keyOut,
        output keyValid,
        output count,
        output full,
        output empty
    );
endinterface

// File: rtl/key_store.sv
// First-word-fall-through key FIFO with a registered one-cycle
// write acknowledge that throttles the producer to one key per 2 cycles.
module key_store #(
    parameter int DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    key_store_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          ack;
    logic          pop;
    logic          accept;
    logic          is_full;
    logic          is_empty;

    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);
    assign pop      = bus.keyTaken && !is_empty;

    // A pop in the same cycle frees the slot a full FIFO needs.
    assign accept = bus.writeReq && !ack &&
                    (!is_full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ack  <= 1'b0;
        end else begin
            ack <= accept;
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= bus.key;
    end

    assign bus.writeSucceeded = ack;
    assign bus.keyValid       = !is_empty;
    assign bus.keyOut         = is_empty ? 32'h0 : mem[rptr];
    assign bus.count          = cnt;
    assign bus.full           = is_full;
    assign bus.empty          = is_empty;
endmodule

// File: tb/tb_key_store.sv
// Directed bench for key_store: stimulus queues expected pop data,
// a negedge monitor checks every popped key and ack pulse width.
module tb_key_store;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic prev_ack;
    logic [31:0] exp_q [$];

    key_store_if #(.DEPTH(4)) bus ();

    key_store #(.DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_ack = 1'b0;
        end else begin
            if (bus.keyTaken && bus.keyValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %h",
                             bus.keyOut);
                end else begin
                    chk("pop_data", bus.keyOut,
                        exp_q.pop_front());
                end
            end
            if (bus.writeSucceeded)
                chk("ack_single", {31'b0, prev_ack}, 32'h0);
            prev_ack = bus.writeSucceeded;
        end
    end

    task automatic status(input string tag,
                          input int c,
                          input logic [31:0] ko);
        chk({tag, "_count"}, 32'(bus.count), 32'(c));
        chk({tag, "_full"}, {31'b0, bus.full},
            {31'b0, c == 4});
        chk({tag, "_empty"}, {31'b0, bus.empty},
            {31'b0, c == 0});
        chk({tag, "_valid"}, {31'b0, bus.keyValid},
            {31'b0, c != 0});
        chk({tag, "_keyout"}, bus.keyOut, ko);
    endtask

    task automatic write_key(input logic [31:0] k,
                             input logic take);
        bit seen;
        seen = 1'b0;
        exp_q.push_back(k);
        @(posedge clk); #1;
        bus.writeReq = 1'b1;
        bus.key      = k;
        bus.keyTaken = take;
        @(posedge clk); #1;
        bus.keyTaken = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.writeSucceeded) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout: key %h no ack", k);
        end
        @(posedge clk); #1;
        bus.writeReq = 1'b0;
    endtask

    task automatic pop_n(input int n);
        @(posedge clk); #1;
        bus.keyTaken = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.keyTaken = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        prev_ack = 1'b0;
        rst          = 1'b0;
        bus.writeReq = 1'b0;
        bus.key      = 32'h0;
        bus.keyTaken = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, bus.writeSucceeded}, 32'h0);
        status("rst", 0, 32'h0);
        #2 rst = 1'b1;

        // Held request spanning the ack cycle stores only once
        @(posedge clk); #1;
        bus.writeReq = 1'b1;
        bus.key      = 32'hF000000F;
        @(negedge clk);
        chk("hold_ack0", {31'b0, bus.writeSucceeded}, 32'h0);
        status("hold_pre", 0, 32'h0);
        @(negedge clk);
        chk("hold_ack1", {31'b0, bus.writeSucceeded}, 32'h1);
        status("hold_acc", 1, 32'hF000000F);
        @(posedge clk); #1;
        bus.writeReq = 1'b0;
        @(negedge clk);
        chk("hold_ack2", {31'b0, bus.writeSucceeded}, 32'h0);
        status("hold_one", 1, 32'hF000000F);
        exp_q.push_back(32'hF000000F);
        pop_n(1);
        @(negedge clk);
        status("hold_drain", 0, 32'h0);

        // Fill, stall a 5th write, then free a slot with a pop
        for (int i = 1; i <= 4; i++)
            write_key(32'(i), 1'b0);
        @(negedge clk);
        status("fill", 4, 32'h1);
        @(posedge clk); #1;
        bus.writeReq = 1'b1;
        bus.key      = 32'h5;
        repeat (3) @(negedge clk);
        chk("stall_ack", {31'b0, bus.writeSucceeded}, 32'h0);
        status("stall", 4, 32'h1);
        exp_q.push_back(32'h5);
        @(posedge clk); #1;
        bus.keyTaken = 1'b1;
        @(posedge clk); #1;
        bus.keyTaken = 1'b0;
        @(negedge clk);
        chk("full_ack", {31'b0, bus.writeSucceeded}, 32'h1);
        status("full_swap", 4, 32'h2);
        @(posedge clk); #1;
        bus.writeReq = 1'b0;
        pop_n(4);
        @(negedge clk);
        status("full_drain", 0, 32'h0);

        // Interleaved traffic wrapping both pointers twice
        write_key(32'hA0, 1'b0);
        write_key(32'hA1, 1'b0);
        write_key(32'hA2, 1'b0);
        pop_n(2);
        write_key(32'hA3, 1'b0);
        write_key(32'hA4, 1'b0);
        write_key(32'hA5, 1'b0);
        @(negedge clk);
        status("wrap_mid", 4, 32'hA2);
        pop_n(3);
        @(negedge clk);
        status("wrap_one", 1, 32'hA5);
        write_key(32'hA6, 1'b1);
        @(negedge clk);
        status("wr_pop_one", 1, 32'hA6);
        pop_n(1);
        @(negedge clk);
        status("wrap_end", 0, 32'h0);

        // Pops while empty must not move the read pointer
        pop_n(3);
        @(negedge clk);
        status("empty_pop", 0, 32'h0);
        write_key(32'hB1, 1'b0);
        @(negedge clk);
        status("empty_wr", 1, 32'hB1);
        pop_n(1);

        // Asynchronous reset during an ack with 3 entries
        write_key(32'hC0, 1'b0);
        write_key(32'hC1, 1'b0);
        @(posedge clk); #1;
        bus.writeReq = 1'b1;
        bus.key      = 32'hC2;
        @(posedge clk); #2;
        chk("pre_rst_ack", {31'b0, bus.writeSucceeded}, 32'h1);
        chk("pre_rst_cnt", 32'(bus.count), 32'h3);
        rst = 1'b0;
        bus.writeReq = 1'b0;
        #1;
        chk("async_ack", {31'b0, bus.writeSucceeded}, 32'h0);
        status("async", 0, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        write_key(32'hD0, 1'b0);
        @(negedge clk);
        status("post_rst", 1, 32'hD0);
        pop_n(1);
        @(negedge clk);
        status("final", 0, 32'h0);
        chk("queue_left", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/key_store.md
KEY_STORE -- requirements
Module: key_store

Interface
REQ-001 Parameter DEPTH, default 4, number of 32-bit key entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; low clears all state immediately.
REQ-004 writeReq  input  1  producer request to store key; held high until writeSucceeded seen.
REQ-005 key  input  32  key to store; valid while writeReq=1.
REQ-006 writeSucceeded  output  1  registered one-cycle acknowledge of an accepted write.
REQ-007 keyOut  output  32  oldest stored key (FIFO head).
REQ-008 keyValid  output  1  high when at least one key stored.
REQ-009 keyTaken  input  1  consumer pops head this cycle when keyValid=1.
REQ-010 count  output  log2(DEPTH)+1  number of stored keys, 0..DEPTH.
REQ-011 full  output  1  count==DEPTH.
REQ-012 empty  output  1  count==0.

Function
REQ-013 Block SHALL be a FIFO of DEPTH 32-bit entries with write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-014 Accept condition: writeReq=1 and writeSucceeded=0 and (full=0 or (keyTaken=1 and keyValid=1)) in the same cycle.
REQ-015 On accept, key SHALL be written at write pointer on that edge and writeSucceeded SHALL be 1 for exactly the following cycle.
REQ-016 writeSucceeded=1 SHALL block acceptance in that cycle, so a held writeReq during the acknowledge cycle stores nothing; max rate one write per 2 cycles.
REQ-017 When writeReq=1 and not accepted (full, no pop), writeSucceeded SHALL stay 0 and key SHALL be ignored; request remains pending with no timeout.
REQ-018 Pop: keyTaken=1 with keyValid=1 SHALL advance read pointer; keyTaken with keyValid=0 SHALL be ignored.
REQ-019 keyOut SHALL be first-word-fall-through: equals head entry whenever keyValid=1, 32'h00000000 when empty.
REQ-020 Write and pop in the same cycle: count unchanged; at count==1, after the edge keyOut is the newly written key.
REQ-021 Write into empty FIFO: keyValid=1 and keyOut=key on the edge following accept (same edge writeSucceeded rises).
REQ-022 count, full, empty, keyValid SHALL be derived from registered state only; no combinational path from writeReq/key to any output except through registers.
REQ-023 count SHALL never exceed DEPTH nor underflow below 0.
REQ-024 Stored data SHALL be returned in write order across any number of pointer wraps.

Reset
REQ-025 While rst=0: writeSucceeded=0, keyValid=0, keyOut=0, count=0, full=0, empty=1, both pointers 0.
REQ-026 Reset mid-operation SHALL discard all entries and any pending acknowledge; an unacknowledged writeReq held across reset release is accepted as a new write.
REQ-027 Memory array contents need not be reset; they SHALL be unobservable while empty.

Verification
REQ-028 Reset, then writeReq=1, key=32'hF000000F held 3 cycles -> writeSucceeded high exactly 1 cycle after first accept edge, count=1, keyOut=32'hF000000F, no second entry.
REQ-029 Write 4 keys 0x1..0x4 with keyTaken=0 -> full=1, count=4; 5th writeReq key=0x5 held -> writeSucceeded stays 0; one-cycle keyTaken -> 0x5 accepted same cycle, ack next cycle, count=4, next keyOut=0x2.
REQ-030 Interleave 7 writes (0xA0..0xA6) with pops so pointers wrap twice -> popped sequence exactly 0xA0..0xA6, count returns to 0, empty=1, keyOut=0.
REQ-031 keyTaken=1 for 3 cycles while empty -> count=0, empty=1, keyValid=0, no pointer movement (next write appears at keyOut).
REQ-032 rst driven low asynchronously during writeSucceeded=1 with count=3 -> writeSucceeded, keyValid, count go to 0 without a clock edge; after release, FIFO accepts a write as from power-up.
